// File: rtl/left_rotate_seq.sv
// left_rotate_seq: sequential 16-bit left rotate by 0..15, one barrel stage (8,4,2,1) per cycle.
// Optional build macro LEFT_ROTATE_SHL_MODE_EN adds a Mode input (1 = shift-left-logical, 0 = rotate).
module left_rotate_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
`ifdef LEFT_ROTATE_SHL_MODE_EN
    input  logic        Mode,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] Out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] work_q, work_d, out_q, out_d, stage_out;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  stage_q, stage_d;
    logic        done_q, done_d, wrap_en;
    logic [4:0]  amt;

`ifdef LEFT_ROTATE_SHL_MODE_EN
    logic mode_q, mode_d;
    assign wrap_en = ~mode_q;
`else
    assign wrap_en = 1'b1;
`endif

    // current stage: shift by 8,4,2,1 and wrap the evicted bits back in unless zero-filling
    always_comb begin
        amt       = 5'd8 >> stage_q;
        stage_out = (work_q << amt) | (wrap_en ? (work_q >> (5'd16 - amt)) : 16'h0000);
    end

    // next-state and datapath updates; Out only changes when leaving DONE
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        out_d   = out_q;
        done_d  = 1'b0;
`ifdef LEFT_ROTATE_SHL_MODE_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                work_d  = In;
                cnt_d   = Cnt;
                stage_d = 2'd0;
                state_d = RUN;
`ifdef LEFT_ROTATE_SHL_MODE_EN
                mode_d  = Mode;
`endif
            end
            RUN: begin
                work_d  = cnt_q[2'd3 - stage_q] ? stage_out : work_q;
                stage_d = stage_q + 2'd1;
                state_d = (stage_q == 2'd3) ? DONE : RUN;
            end
            DONE: begin
                out_d   = work_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= 16'h0000;
            cnt_q   <= 4'h0;
            stage_q <= 2'd0;
            out_q   <= 16'h0000;
            done_q  <= 1'b0;
`ifdef LEFT_ROTATE_SHL_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            done_q  <= done_d;
`ifdef LEFT_ROTATE_SHL_MODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign Out  = out_q;
endmodule

// File: tb/tb_left_rotate_seq.sv
// tb_left_rotate_seq: directed and random checks of left_rotate_seq against an arithmetic rotate model.
module tb_left_rotate_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] In = 16'h0;
    logic [3:0]  Cnt = 4'h0;
    logic        busy, done;
    logic [15:0] Out;
    logic        mode = 1'b0;
    int checks = 0;
    int errors = 0;

    left_rotate_seq dut (
        .clk(clk), .rst(rst), .start(start), .In(In), .Cnt(Cnt),
`ifdef LEFT_ROTATE_SHL_MODE_EN
        .Mode(mode),
`endif
        .busy(busy), .done(done), .Out(Out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_out(input logic [15:0] a, input int k, input logic m);
        int v;
        v = int'(a) << k;
`ifdef LEFT_ROTATE_SHL_MODE_EN
        if (!m) v = v | (int'(a) >> (16 - k));
`else
        v = v | (int'(a) >> (16 - k));
`endif
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [3:0] k, input logic m, input bit spam,
                          input logic [15:0] exp);
        logic [15:0] prev;
        int n, busy_n;
        bit got;
        @(negedge clk);
        In = a; Cnt = k; mode = m; start = 1'b1;
        @(posedge clk); #1;
        check("busy_on", busy, 1);
        prev = Out; busy_n = 1; n = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (spam) begin
                start = 1'b1; In = 16'($urandom); Cnt = 4'($urandom); mode = 1'($urandom);
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
            else begin
                if (busy) busy_n++;
                check("out_hold", Out, prev);
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("latency", n, 5);
        check("busy_cycles", busy_n, 5);
        check("out", Out, exp);
        check("idle_at_done", busy, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("out_keep", Out, exp);
    endtask

    initial begin
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", Out, 0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        run_op(16'h1234, 4'd8, 1'b0, 0, 16'h3412);
        run_op(16'h1234, 4'd4, 1'b0, 0, 16'h2341);
        run_op(16'h8001, 4'd15, 1'b0, 0, 16'hC000);
        run_op(16'hBEEF, 4'd0, 1'b0, 0, 16'hBEEF);
        run_op(16'h00FF, 4'd1, 1'b0, 1, 16'h01FE);
`ifdef LEFT_ROTATE_SHL_MODE_EN
        run_op(16'h1234, 4'd4, 1'b1, 0, 16'h2340);
        run_op(16'h1234, 4'd4, 1'b0, 0, 16'h2341);
`endif

        // reset in the middle of RUN must clear everything at once
        @(negedge clk);
        In = 16'hA5A5; Cnt = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out", Out, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
        end
        run_op(16'h1234, 4'd8, 1'b0, 0, 16'h3412);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] a;
            logic [3:0] k;
            logic m;
            a = 16'($urandom);
            k = 4'($urandom);
            m = 1'($urandom);
`ifndef LEFT_ROTATE_SHL_MODE_EN
            m = 1'b0;
`endif
            run_op(a, k, m, bit'($urandom_range(0, 1)), ref_out(a, int'(k), m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end
endmodule
